multi_delta_counter: RTL and testbench
======================================

MULTI_DELTA_COUNTER -- requirements
Module: multi_delta_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the counter width per channel in bits (minimum 2).
REQ-002 The block SHALL have parameter CHANNELS, default 4, giving the number of independent counters (minimum 1).
REQ-003 The block SHALL have parameter SATURATE, default 0, selecting wrap mode (0) or saturate mode (1) for all channels.
REQ-004 The block SHALL have port clk_i, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit, the reset; it is synchronous and active-high.
REQ-006 The block SHALL have port clear_i, input, CHANNELS bits, the per-channel clear.
REQ-007 The block SHALL have port load_i, input, CHANNELS bits, the per-channel load of d_i.
REQ-008 The block SHALL have port en_i, input, CHANNELS bits, the per-channel count enable.
REQ-009 The block SHALL have port down_i, input, CHANNELS bits, the per-channel direction (1 = subtract delta).
REQ-010 The block SHALL have port delta_i, input, CHANNELS*WIDTH bits, the per-channel step; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-011 The block SHALL have port d_i, input, CHANNELS*WIDTH bits, the per-channel load value, packed as delta_i.
REQ-012 The block SHALL have port q_o, output, CHANNELS*WIDTH bits, the per-channel registered count, packed as delta_i.
REQ-013 The block SHALL have port overflow_o, output, CHANNELS bits, the per-channel sticky overflow flag for up-count past 2^WIDTH-1.
REQ-014 The block SHALL have port underflow_o, output, CHANNELS bits, the per-channel sticky underflow flag for down-count below 0.

Function
REQ-015 Each channel SHALL be fully independent; no input of channel c SHALL affect the state of any other channel.
REQ-016 Per-channel update priority SHALL be, highest first: clear_i, then load_i, then en_i, then hold.
REQ-017 Clear SHALL set the count to 0 and both flags to 0 on the next edge.
REQ-018 Load SHALL set the count to d_i and both flags to 0 on the next edge.
REQ-019 An up-count SHALL compute count + delta at WIDTH+1 bits; a carry out SHALL set overflow.
REQ-020 A down-count SHALL compute count - delta at WIDTH+1 bits; a borrow SHALL set underflow.
REQ-021 In wrap mode (SATURATE=0), the stored count SHALL be the low WIDTH bits of the sum or difference.
REQ-022 In saturate mode (SATURATE=1), overflow SHALL clamp the count to 2^WIDTH-1 and underflow SHALL clamp it to 0; the flags SHALL still set.
REQ-023 Once set, a flag SHALL remain 1 until a clear, a load or a reset of that channel; further counting SHALL NOT clear it.
REQ-024 With delta = 0 and en_i = 1, the count SHALL hold and the flags SHALL be unchanged.
REQ-025 Latency SHALL be one cycle: q_o and the flags reflect the inputs sampled at the previous rising edge; all outputs SHALL be registered.
REQ-026 An exact landing on 2^WIDTH-1 (up) or on 0 (down) SHALL NOT set a flag.

Reset
REQ-027 While rst_i = 1 at a rising edge, every q_o channel SHALL become 0 and every overflow_o, underflow_o (and hit_o, if present) bit SHALL become 0.
REQ-028 rst_i SHALL override clear_i, load_i and en_i, including a reset asserted in the middle of counting.
REQ-029 Counting SHALL resume on the first edge after rst_i deasserts.

Configuration
REQ-030 When macro MULTI_DELTA_COUNTER_THRESH_EN is defined, the block SHALL add input thresh_i (CHANNELS*WIDTH bits) and output hit_o (CHANNELS bits).
REQ-031 With MULTI_DELTA_COUNTER_THRESH_EN defined, hit_o[c] SHALL be a registered one-cycle pulse, aligned with q_o, asserted when a load or count update produces a new value equal to thresh_i[c].
REQ-032 With MULTI_DELTA_COUNTER_THRESH_EN defined, a hold SHALL NOT produce a hit_o pulse, and a clear SHALL NOT produce a hit_o pulse.
REQ-033 When MULTI_DELTA_COUNTER_THRESH_EN is undefined, thresh_i and hit_o SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-034 Reset: rst_i = 1 for 2 cycles after arbitrary counting -> all q_o = 0 and all flags = 0 on the first edge.
REQ-035 Independence (WIDTH=8, CHANNELS=4): ch0 counts up by 1 for 5 cycles while ch1 loads 10 then counts down by 2 for 3 cycles -> ch0 = 5, ch1 = 4, ch2 = 0 and ch3 = 0.
REQ-036 Wrap and sticky flag (SATURATE=0): ch2 loads 250, counts up by 10 -> q = 4 with overflow_o[2] = 1; next count up by 1 -> q = 5 with the flag still 1; clear -> q = 0 with the flag 0.
REQ-037 Saturate (SATURATE=1): load 5, count down by 8 -> q = 0 with underflow = 1; load 250, count up by 10 -> q = 255 with overflow = 1 and underflow = 0.
REQ-038 Priority: clear, load (d = 77) and en asserted in the same cycle -> q = 0; load (d = 77) and en asserted together -> q = 77; delta = 0 with en = 1 -> q holds.
REQ-039 Threshold (macro defined): thresh = 7, count up by 1 from 0 -> hit_o pulses for exactly one cycle, coincident with q_o = 7, and does not pulse while q holds at 7.

Source files
------------

// File: rtl/multi_delta_counter.sv
// multi_delta_counter
//   A bank of CHANNELS independent up/down counters, each WIDTH bits wide.
//   Every channel steps by its own delta and can either wrap or saturate
//   (SATURATE parameter, shared by all channels). Each channel keeps sticky
//   overflow/underflow flags. All outputs are registered, so they follow the
//   inputs sampled at an edge by exactly one cycle.
//
//   Per-channel update priority: clear > load > enable > hold.
//   A count step with delta = 0 leaves the count and the flags unchanged.
//
// Optional feature (macro MULTI_DELTA_COUNTER_THRESH_EN):
//   Adds thresh_i and hit_o. hit_o[c] is a one-cycle registered pulse,
//   aligned with q_o, raised when a load or a non-zero count step produces a
//   value equal to the channel's threshold. Clear and hold never pulse.
//
// Ports
//   clk_i        clock, all state updates on the rising edge
//   rst_i        synchronous active-high reset, overrides everything
//   clear_i      per-channel clear (count and flags to 0)
//   load_i       per-channel load of d_i (flags to 0)
//   en_i         per-channel count enable
//   down_i       per-channel direction, 1 = subtract delta
//   delta_i      per-channel step, channel c at [c*WIDTH +: WIDTH]
//   d_i          per-channel load value, packed as delta_i
//   thresh_i     per-channel hit threshold (feature macro only)
//   hit_o        per-channel threshold pulse (feature macro only)
//   q_o          per-channel registered count, packed as delta_i
//   overflow_o   per-channel sticky overflow flag
//   underflow_o  per-channel sticky underflow flag
module multi_delta_counter #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SATURATE = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [CHANNELS-1:0]       clear_i,
  input  logic [CHANNELS-1:0]       load_i,
  input  logic [CHANNELS-1:0]       en_i,
  input  logic [CHANNELS-1:0]       down_i,
  input  logic [CHANNELS*WIDTH-1:0] delta_i,
  input  logic [CHANNELS*WIDTH-1:0] d_i,
`ifdef MULTI_DELTA_COUNTER_THRESH_EN
  input  logic [CHANNELS*WIDTH-1:0] thresh_i,
  output logic [CHANNELS-1:0]       hit_o,
`endif
  output logic [CHANNELS*WIDTH-1:0] q_o,
  output logic [CHANNELS-1:0]       overflow_o,
  output logic [CHANNELS-1:0]       underflow_o
);

  localparam logic [WIDTH-1:0] ZERO_COUNT = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] MAX_COUNT  = {WIDTH{1'b1}};

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] delta_s;
    logic [WIDTH-1:0] d_s;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] cnt_next_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic             ovf_r;
    logic             ovf_next_s;
    logic             unf_r;
    logic             unf_next_s;

    assign delta_s = delta_i[c*WIDTH +: WIDTH];
    assign d_s     = d_i[c*WIDTH +: WIDTH];

    // One extra bit exposes the carry (up) or the borrow (down).
    assign sum_s  = {1'b0, cnt_r} + {1'b0, delta_s};
    assign diff_s = {1'b0, cnt_r} - {1'b0, delta_s};

    // Next count and sticky flags, in clear > load > enable > hold order
    always_comb begin
      cnt_next_s = cnt_r;
      ovf_next_s = ovf_r;
      unf_next_s = unf_r;
      if (clear_i[c]) begin
        cnt_next_s = ZERO_COUNT;
        ovf_next_s = 1'b0;
        unf_next_s = 1'b0;
      end else if (load_i[c]) begin
        cnt_next_s = d_s;
        ovf_next_s = 1'b0;
        unf_next_s = 1'b0;
      end else if (en_i[c]) begin
        if (down_i[c]) begin
          if (diff_s[WIDTH]) begin
            unf_next_s = 1'b1;
            if (SATURATE != 0) begin
              cnt_next_s = ZERO_COUNT;
            end else begin
              cnt_next_s = diff_s[WIDTH-1:0];
            end
          end else begin
            cnt_next_s = diff_s[WIDTH-1:0];
          end
        end else begin
          if (sum_s[WIDTH]) begin
            ovf_next_s = 1'b1;
            if (SATURATE != 0) begin
              cnt_next_s = MAX_COUNT;
            end else begin
              cnt_next_s = sum_s[WIDTH-1:0];
            end
          end else begin
            cnt_next_s = sum_s[WIDTH-1:0];
          end
        end
      end else begin
        cnt_next_s = cnt_r;
      end
    end

    // Count and flag registers with synchronous reset
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_r <= ZERO_COUNT;
        ovf_r <= 1'b0;
        unf_r <= 1'b0;
      end else begin
        cnt_r <= cnt_next_s;
        ovf_r <= ovf_next_s;
        unf_r <= unf_next_s;
      end
    end

    assign q_o[c*WIDTH +: WIDTH] = cnt_r;
    assign overflow_o[c]         = ovf_r;
    assign underflow_o[c]        = unf_r;

`ifdef MULTI_DELTA_COUNTER_THRESH_EN
    logic [WIDTH-1:0] thresh_s;
    logic             hit_r;
    logic             hit_next_s;

    assign thresh_s = thresh_i[c*WIDTH +: WIDTH];

    // Threshold match; a zero-delta step is a hold, so it cannot pulse
    always_comb begin
      hit_next_s = 1'b0;
      if (clear_i[c]) begin
        hit_next_s = 1'b0;
      end else if (load_i[c]) begin
        hit_next_s = (d_s == thresh_s);
      end else if (en_i[c] && (delta_s != ZERO_COUNT)) begin
        hit_next_s = (cnt_next_s == thresh_s);
      end else begin
        hit_next_s = 1'b0;
      end
    end

    // Hit pulse register, aligned with the count register
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        hit_r <= 1'b0;
      end else begin
        hit_r <= hit_next_s;
      end
    end

    assign hit_o[c] = hit_r;
`endif
  end

endmodule

// File: tb/tb_multi_delta_counter.sv
module tb_multi_delta_counter;
  localparam int W = 8;
  localparam int N = 4;

  logic clk_r = 1'b0;
  always #5 clk_r = ~clk_r;

  logic        rst_r;
  logic [3:0]  clear_r, load_r, en_r, down_r;
  logic [31:0] delta_r, d_r;
  logic [31:0] q_s, qs_s;
  logic [3:0]  ovf_s, unf_s, ovfs_s, unfs_s, hit_s, hits_s;
  logic [87:0] obs_s;
`ifdef MULTI_DELTA_COUNTER_THRESH_EN
  logic [31:0] thresh_r;
`else
  assign hit_s  = 4'b0000;
  assign hits_s = 4'b0000;
`endif

  // wrap instance in the upper half, saturate instance in the lower half
  assign obs_s = {hit_s, q_s, ovf_s, unf_s, hits_s, qs_s, ovfs_s, unfs_s};

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [87:0] sb[$];
  logic [87:0] e;
  int          mq[2][4];
  bit          mo[2][4];
  bit          mu[2][4];

  multi_delta_counter #(.WIDTH(W), .CHANNELS(N), .SATURATE(0)) dut (
    .clk_i(clk_r), .rst_i(rst_r), .clear_i(clear_r), .load_i(load_r),
    .en_i(en_r), .down_i(down_r), .delta_i(delta_r), .d_i(d_r),
`ifdef MULTI_DELTA_COUNTER_THRESH_EN
    .thresh_i(thresh_r), .hit_o(hit_s),
`endif
    .q_o(q_s), .overflow_o(ovf_s), .underflow_o(unf_s)
  );

  multi_delta_counter #(.WIDTH(W), .CHANNELS(N), .SATURATE(1)) dut_sat (
    .clk_i(clk_r), .rst_i(rst_r), .clear_i(clear_r), .load_i(load_r),
    .en_i(en_r), .down_i(down_r), .delta_i(delta_r), .d_i(d_r),
`ifdef MULTI_DELTA_COUNTER_THRESH_EN
    .thresh_i(thresh_r), .hit_o(hits_s),
`endif
    .q_o(qs_s), .overflow_o(ovfs_s), .underflow_o(unfs_s)
  );

  // Reference model: predicts both instances from the current inputs,
  // queues the expectation, then advances one clock.
  task automatic step();
    logic [43:0] part [2];
    logic [31:0] eq;
    logic [3:0]  eo, eu, eh;
    int dl, dv, t;
    bit h;
    for (int s = 0; s < 2; s++) begin
      eq = 32'd0; eo = 4'd0; eu = 4'd0; eh = 4'd0;
      for (int c = 0; c < 4; c++) begin
        dl = int'(delta_r[c*8 +: 8]);
        dv = int'(d_r[c*8 +: 8]);
        h  = 1'b0;
        if (rst_r) begin
          mq[s][c] = 0; mo[s][c] = 1'b0; mu[s][c] = 1'b0;
        end else if (clear_r[c]) begin
          mq[s][c] = 0; mo[s][c] = 1'b0; mu[s][c] = 1'b0;
        end else if (load_r[c]) begin
          mq[s][c] = dv; mo[s][c] = 1'b0; mu[s][c] = 1'b0;
          h = 1'b1;
        end else if (en_r[c] && dl != 0) begin
          if (down_r[c]) begin
            t = mq[s][c] - dl;
            if (t < 0) begin
              mu[s][c] = 1'b1;
              t = (s == 1) ? 0 : t + 256;
            end
          end else begin
            t = mq[s][c] + dl;
            if (t > 255) begin
              mo[s][c] = 1'b1;
              t = (s == 1) ? 255 : t - 256;
            end
          end
          mq[s][c] = t;
          h = 1'b1;
        end
`ifdef MULTI_DELTA_COUNTER_THRESH_EN
        eh[c] = h && (mq[s][c] == int'(thresh_r[c*8 +: 8]));
`else
        eh[c] = 1'b0;
`endif
        eq[c*8 +: 8] = 8'(mq[s][c]);
        eo[c] = mo[s][c];
        eu[c] = mu[s][c];
      end
      part[s] = {eh, eq, eo, eu};
    end
    sb.push_back({part[0], part[1]});
    @(posedge clk_r);
    #1;
  endtask

  task automatic idle();
    rst_r = 1'b0; clear_r = 4'd0; load_r = 4'd0; en_r = 4'd0; down_r = 4'd0;
    delta_r = 32'd0; d_r = 32'd0;
  endtask

  task automatic test_reset();
    idle();
    rst_r = 1'b1;
    step();
    e = sb.pop_front(); n_checks++;
    if (obs_s !== e) begin n_fail++; $display("FAIL por: got %h expected %h", obs_s, e); end
    rst_r = 1'b0;
    for (int i = 0; i < 24; i++) begin
      clear_r = ($urandom_range(0, 7) == 0) ? 4'($urandom()) : 4'd0;
      load_r  = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'd0;
      en_r    = 4'($urandom());
      down_r  = 4'($urandom());
      delta_r = $urandom();
      d_r     = $urandom();
      step();
      e = sb.pop_front(); n_checks++;
      if (obs_s !== e) begin n_fail++; $display("FAIL rnd_%0d: got %h expected %h", i, obs_s, e); end
    end
    en_r = 4'hF; load_r = 4'h0; clear_r = 4'h0; rst_r = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      e = sb.pop_front(); n_checks++;
      if (obs_s !== e) begin n_fail++; $display("FAIL rst_%0d: got %h expected %h", i, obs_s, e); end
      n_checks++;
      if ({q_s, ovf_s, unf_s, qs_s, ovfs_s, unfs_s} !== 80'd0) begin
        n_fail++; $display("FAIL rst_zero_%0d: got %h expected 0", i, {q_s, ovf_s, unf_s, qs_s, ovfs_s, unfs_s});
      end
    end
    idle();
    en_r = 4'b0001; delta_r = 32'd1;
    step();
    e = sb.pop_front(); n_checks++;
    if (q_s[7:0] !== 8'd1) begin n_fail++; $display("FAIL rst_resume: got %0d expected 1", q_s[7:0]); end
  endtask

  task automatic test_independence();
    idle();
    clear_r = 4'hF;
    step();
    e = sb.pop_front(); n_checks++;
    if (obs_s !== e) begin n_fail++; $display("FAIL ind_clr: got %h expected %h", obs_s, e); end
    clear_r = 4'h0;
    delta_r = {8'd0, 8'd0, 8'd2, 8'd1};
    d_r     = {8'd0, 8'd0, 8'd10, 8'd0};
    down_r  = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      load_r = (k == 0) ? 4'b0010 : 4'b0000;
      en_r   = (k >= 1 && k <= 3) ? 4'b0011 : 4'b0001;
      step();
      e = sb.pop_front(); n_checks++;
      if (obs_s !== e) begin n_fail++; $display("FAIL ind_%0d: got %h expected %h", k, obs_s, e); end
    end
    n_checks++;
    if (q_s !== 32'h00_00_04_05) begin n_fail++; $display("FAIL ind_final: got %h expected 00000405", q_s); end
  endtask

  task automatic test_wrap();
    idle();
    load_r = 4'b0100; d_r = 32'd250 << 16;
    step(); e = sb.pop_front();
    load_r = 4'b0000; en_r = 4'b0100; delta_r = 32'd10 << 16;
    step();
    e = sb.pop_front(); n_checks++;
    if (obs_s !== e) begin n_fail++; $display("FAIL wrap_sb: got %h expected %h", obs_s, e); end
    n_checks++;
    if (q_s[23:16] !== 8'd4 || ovf_s[2] !== 1'b1) begin
      n_fail++; $display("FAIL wrap_ovf: got q=%0d ovf=%b expected q=4 ovf=1", q_s[23:16], ovf_s[2]);
    end
    delta_r = 32'd1 << 16;
    step(); e = sb.pop_front(); n_checks++;
    if (q_s[23:16] !== 8'd5 || ovf_s[2] !== 1'b1) begin
      n_fail++; $display("FAIL wrap_sticky: got q=%0d ovf=%b expected q=5 ovf=1", q_s[23:16], ovf_s[2]);
    end
    en_r = 4'b0000; clear_r = 4'b0100;
    step(); e = sb.pop_front(); n_checks++;
    if (q_s[23:16] !== 8'd0 || ovf_s[2] !== 1'b0) begin
      n_fail++; $display("FAIL wrap_clear: got q=%0d ovf=%b expected q=0 ovf=0", q_s[23:16], ovf_s[2]);
    end
  endtask

  task automatic test_saturate();
    idle();
    load_r = 4'b1000; d_r = 32'd5 << 24;
    step(); e = sb.pop_front();
    load_r = 4'b0000; en_r = 4'b1000; down_r = 4'b1000; delta_r = 32'd8 << 24;
    step();
    e = sb.pop_front(); n_checks++;
    if (obs_s !== e) begin n_fail++; $display("FAIL sat_sb: got %h expected %h", obs_s, e); end
    n_checks++;
    if (qs_s[31:24] !== 8'd0 || unfs_s[3] !== 1'b1) begin
      n_fail++; $display("FAIL sat_unf: got q=%0d unf=%b expected q=0 unf=1", qs_s[31:24], unfs_s[3]);
    end
    en_r = 4'b0000; down_r = 4'b0000; load_r = 4'b1000; d_r = 32'd250 << 24;
    step(); e = sb.pop_front();
    load_r = 4'b0000; en_r = 4'b1000; delta_r = 32'd10 << 24;
    step(); e = sb.pop_front(); n_checks++;
    if (qs_s[31:24] !== 8'd255 || ovfs_s[3] !== 1'b1 || unfs_s[3] !== 1'b0) begin
      n_fail++; $display("FAIL sat_ovf: got q=%0d ovf=%b unf=%b expected q=255 ovf=1 unf=0", qs_s[31:24], ovfs_s[3], unfs_s[3]);
    end
  endtask

  task automatic test_priority();
    idle();
    clear_r = 4'b0001; load_r = 4'b0001; en_r = 4'b0001; d_r = 32'd77; delta_r = 32'd3;
    step(); e = sb.pop_front(); n_checks++;
    if (q_s[7:0] !== 8'd0) begin n_fail++; $display("FAIL prio_clear: got %0d expected 0", q_s[7:0]); end
    clear_r = 4'b0000;
    step(); e = sb.pop_front(); n_checks++;
    if (q_s[7:0] !== 8'd77) begin n_fail++; $display("FAIL prio_load: got %0d expected 77", q_s[7:0]); end
    load_r = 4'b0000; delta_r = 32'd0;
    step();
    e = sb.pop_front(); n_checks++;
    if (obs_s !== e) begin n_fail++; $display("FAIL prio_sb: got %h expected %h", obs_s, e); end
    n_checks++;
    if (q_s[7:0] !== 8'd77 || ovf_s[0] !== 1'b0 || unf_s[0] !== 1'b0) begin
      n_fail++; $display("FAIL prio_hold: got q=%0d expected 77 with no flags", q_s[7:0]);
    end
  endtask

  task automatic test_boundaries();
    idle();
    load_r = 4'b0010; d_r = 32'd245 << 8;
    step(); e = sb.pop_front();
    load_r = 4'b0000; en_r = 4'b0010; delta_r = 32'd10 << 8;
    step(); e = sb.pop_front(); n_checks++;
    if (q_s[15:8] !== 8'd255 || ovf_s[1] !== 1'b0 || ovfs_s[1] !== 1'b0) begin
      n_fail++; $display("FAIL land_max: got q=%0d ovf=%b expected q=255 ovf=0", q_s[15:8], ovf_s[1]);
    end
    en_r = 4'b0000; load_r = 4'b0010; d_r = 32'd10 << 8;
    step(); e = sb.pop_front();
    load_r = 4'b0000; en_r = 4'b0010; down_r = 4'b0010;
    step();
    e = sb.pop_front(); n_checks++;
    if (obs_s !== e) begin n_fail++; $display("FAIL land_sb: got %h expected %h", obs_s, e); end
    n_checks++;
    if (q_s[15:8] !== 8'd0 || unf_s[1] !== 1'b0 || unfs_s[1] !== 1'b0) begin
      n_fail++; $display("FAIL land_zero: got q=%0d unf=%b expected q=0 unf=0", q_s[15:8], unf_s[1]);
    end
  endtask

`ifdef MULTI_DELTA_COUNTER_THRESH_EN
  task automatic test_thresh();
    idle();
    thresh_r = {8'hFF, 8'hFF, 8'd7, 8'hFF};
    clear_r = 4'b0010;
    step(); e = sb.pop_front();
    clear_r = 4'b0000; en_r = 4'b0010; delta_r = 32'd1 << 8;
    for (int k = 1; k <= 10; k++) begin
      if (k == 8) en_r = 4'b0000;
      if (k == 10) begin en_r = 4'b0010; delta_r = 32'd0; end
      step();
      e = sb.pop_front(); n_checks++;
      if (obs_s !== e) begin n_fail++; $display("FAIL thr_sb_%0d: got %h expected %h", k, obs_s, e); end
      n_checks++;
      if (hit_s[1] !== (k == 7)) begin
        n_fail++; $display("FAIL thr_hit_%0d: got hit=%b q=%0d expected hit=%b", k, hit_s[1], q_s[15:8], (k == 7));
      end
    end
  endtask
`endif

  initial begin
`ifdef MULTI_DELTA_COUNTER_THRESH_EN
    thresh_r = 32'hFFFF_FFFF;
`endif
    idle();
    test_reset();
    test_independence();
    test_wrap();
    test_saturate();
    test_priority();
    test_boundaries();
`ifdef MULTI_DELTA_COUNTER_THRESH_EN
    test_thresh();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
